sync_fifo: RTL and testbench
============================

SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter dataWidth, default 11: width in bits of each stored word.
REQ-002 Parameter depth, default 4: number of storage entries; SHALL be a power of two, at least 2.
REQ-003 Parameter indxWidth, default 2: pointer width; SHALL equal log2(depth).
REQ-004 sCLK  input  1: sole clock; all state updates on its rising edge.
REQ-005 sRST  input  1: reset, asynchronous, active-high.
REQ-006 dCLK  input  1: retained for port compatibility only; SHALL be ignored internally.
REQ-007 sENQ  input  1: enqueue request, sampled at the rising edge of sCLK.
REQ-008 sD_IN  input  dataWidth: write data, captured when an enqueue is accepted.
REQ-009 sFULL_N  output  1: high when at least one entry is free.
REQ-010 dDEQ  input  1: dequeue request, sampled at the rising edge of sCLK.
REQ-011 dD_OUT  output  dataWidth: oldest stored word (head), first-word-fall-through.
REQ-012 dEMPTY_N  output  1: high when at least one entry holds valid data.

Function
REQ-013 The block SHALL use a circular buffer of depth entries with write pointer, read pointer and occupancy count (0..depth).
REQ-014 An enqueue SHALL be accepted at a clock edge iff sENQ=1 and sFULL_N=1; sD_IN is written at the write pointer, which then advances modulo depth.
REQ-015 A dequeue SHALL be accepted at a clock edge iff dDEQ=1 and dEMPTY_N=1; the read pointer then advances modulo depth.
REQ-016 sENQ while full SHALL be ignored: no write, no pointer or count change, data dropped.
REQ-017 dDEQ while empty SHALL be ignored: no pointer or count change.
REQ-018 Simultaneous accepted enqueue and dequeue SHALL leave the count unchanged and advance both pointers.
REQ-019 When full, sENQ and dDEQ in the same cycle: only the dequeue is accepted, because sFULL_N=0 blocks the enqueue.
REQ-020 When empty, sENQ and dDEQ in the same cycle: only the enqueue is accepted, because dEMPTY_N=0 blocks the dequeue.
REQ-021 sFULL_N and dEMPTY_N SHALL be registered and reflect the post-edge count: sFULL_N = (count != depth), dEMPTY_N = (count != 0).
REQ-022 dD_OUT SHALL present storage[read pointer] combinationally; it is valid whenever dEMPTY_N=1.
REQ-023 Latency: a word enqueued at edge N SHALL be visible on dD_OUT, with dEMPTY_N=1, after edge N if the FIFO was empty.
REQ-024 Ordering: words SHALL be dequeued in exactly the order they were accepted, across any number of pointer wrap-arounds.
REQ-025 dD_OUT is don't-care while dEMPTY_N=0; storage contents are not cleared by reset.

Reset
REQ-026 While sRST=1, regardless of the clock: pointers=0, count=0, sFULL_N=0, dEMPTY_N=0.
REQ-027 On the first rising sCLK edge with sRST=0, sFULL_N SHALL rise to 1; dEMPTY_N stays 0.
REQ-028 Reset asserted mid-operation SHALL discard all contents immediately; sENQ and dDEQ are ignored while sRST=1.

Verification
REQ-029 Reset: hold sRST=1 for 5 cycles, then release -> sFULL_N=0 and dEMPTY_N=0 during reset; sFULL_N=1 and dEMPTY_N=0 one edge after release.
REQ-030 Single word: enqueue 0x5A3 -> dEMPTY_N=1 and dD_OUT=0x5A3 after that edge; dDEQ for one cycle -> dEMPTY_N=0.
REQ-031 Fill/overflow: enqueue 0x001..0x004 -> sFULL_N=0; further enqueue of 0x7FF is dropped; dequeue 4 words -> 0x001,0x002,0x003,0x004, then dEMPTY_N=0.
REQ-032 Underflow: dDEQ=1 for 3 cycles while empty -> no state change; a subsequent enqueue of 0x123 is read back as 0x123.
REQ-033 Streaming: 64 random words, enqueue and dequeue each asserted on alternate cycles while flags permit -> every dequeued word matches a reference queue in order, through at least 16 wrap-arounds.
REQ-034 Full plus simultaneous: when full, assert sENQ(0x0AA) and dDEQ together -> head is removed, 0x0AA is not written, count becomes 3 and sFULL_N=1.

Source files
------------

// File: rtl/sync_fifo.sv
// sync_fifo -- single-clock first-word-fall-through FIFO.
//
// A circular buffer of `depth` words with write pointer, read pointer and
// occupancy count. The full/empty flags are registered and track the count
// after each edge. The head word is presented combinationally on dD_OUT.
//
// Ports
//   sCLK     in   1          clock; every state update on its rising edge
//   sRST     in   1          asynchronous active-high reset
//   dCLK     in   1          kept for port compatibility, not used inside
//   sENQ     in   1          enqueue request (accepted when sFULL_N=1)
//   sD_IN    in   dataWidth  write data
//   sFULL_N  out  1          high while at least one entry is free
//   dDEQ     in   1          dequeue request (accepted when dEMPTY_N=1)
//   dD_OUT   out  dataWidth  head word, valid while dEMPTY_N=1
//   dEMPTY_N out  1          high while at least one entry holds data
`timescale 1ns/1ps
module sync_fifo #(
   parameter int dataWidth = 11,
   parameter int depth     = 4,   // power of two, >= 2
   parameter int indxWidth = 2    // log2(depth)
) (
   input  logic                 sCLK,
   input  logic                 sRST,
   input  logic                 dCLK,
   input  logic                 sENQ,
   input  logic [dataWidth-1:0] sD_IN,
   output logic                 sFULL_N,
   input  logic                 dDEQ,
   output logic [dataWidth-1:0] dD_OUT,
   output logic                 dEMPTY_N
);

   localparam logic [indxWidth:0]   C_FULL_CNT = (indxWidth+1)'(depth);
   localparam logic [indxWidth:0]   C_CNT_ONE  = (indxWidth+1)'(1);
   localparam logic [indxWidth-1:0] C_PTR_ONE  = indxWidth'(1);

   logic [dataWidth-1:0] r_mem [depth];
   logic [indxWidth-1:0] r_wptr;
   logic [indxWidth-1:0] r_rptr;
   logic [indxWidth:0]   r_count;
   logic                 r_full_n;
   logic                 r_empty_n;

   logic [indxWidth:0]   w_count_nxt;
   logic                 w_enq_acc;
   logic                 w_deq_acc;
   logic                 w_unused_dclk;

   assign w_unused_dclk = dCLK;

   // The registered flags gate acceptance, so a full FIFO drops the write
   // and an empty FIFO ignores the read even when both are requested.
   assign w_enq_acc = sENQ & r_full_n;
   assign w_deq_acc = dDEQ & r_empty_n;

   always_comb begin
      w_count_nxt = r_count;
      case ({w_enq_acc, w_deq_acc})
         2'b10:   w_count_nxt = r_count + C_CNT_ONE;
         2'b01:   w_count_nxt = r_count - C_CNT_ONE;
         default: w_count_nxt = r_count;
      endcase
   end

   // Control state: pointers wrap naturally because depth is a power of two.
   // Flags are computed from the next count so they reflect the post-edge
   // occupancy; after reset release the first edge raises sFULL_N.
   always_ff @(posedge sCLK or posedge sRST) begin
      if (sRST) begin
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_count   <= '0;
         r_full_n  <= 1'b0;
         r_empty_n <= 1'b0;
      end else begin
         if (w_enq_acc) r_wptr <= r_wptr + C_PTR_ONE;
         if (w_deq_acc) r_rptr <= r_rptr + C_PTR_ONE;
         r_count   <= w_count_nxt;
         r_full_n  <= (w_count_nxt != C_FULL_CNT);
         r_empty_n <= (w_count_nxt != '0);
      end
   end

   // Storage is deliberately not reset; r_full_n is low during reset so no
   // write can land while sRST is asserted.
   always_ff @(posedge sCLK) begin
      if (w_enq_acc) r_mem[r_wptr] <= sD_IN;
   end

   assign dD_OUT   = r_mem[r_rptr];
   assign sFULL_N  = r_full_n;
   assign dEMPTY_N = r_empty_n;

endmodule

// File: tb/tb_sync_fifo.sv
`timescale 1ns/1ps
module tb_sync_fifo;

   localparam int DW    = 11;
   localparam int DEPTH = 4;
   localparam int IW    = 2;

   logic          sCLK = 1'b0;
   logic          dCLK = 1'b0;
   logic          sRST;
   logic          sENQ;
   logic [DW-1:0] sD_IN;
   logic          sFULL_N;
   logic          dDEQ;
   logic [DW-1:0] dD_OUT;
   logic          dEMPTY_N;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: a plain queue of accepted words, plus a flag meaning
   // "no edge has occurred since reset release" (sFULL_N still 0 then).
   logic [DW-1:0] q[$];
   bit            fresh;

   always #5 sCLK = ~sCLK;
   always #7 dCLK = ~dCLK;

   sync_fifo #(.dataWidth(DW), .depth(DEPTH), .indxWidth(IW)) dut (
      .sCLK(sCLK), .sRST(sRST), .dCLK(dCLK),
      .sENQ(sENQ), .sD_IN(sD_IN), .sFULL_N(sFULL_N),
      .dDEQ(dDEQ), .dD_OUT(dD_OUT), .dEMPTY_N(dEMPTY_N)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got hang required finish");
      $fatal(1, "watchdog");
   end

   // Drive one clock with the given requests and update the model using the
   // pre-edge flags implied by the model state.
   task automatic cycle(input bit enq, input logic [DW-1:0] d, input bit deq);
      bit acc_e;
      bit acc_d;
      sENQ  = enq;
      sD_IN = d;
      dDEQ  = deq;
      acc_e = enq && !fresh && (q.size() < DEPTH);
      acc_d = deq && (q.size() > 0);
      @(posedge sCLK);
      if (acc_d) void'(q.pop_front());
      if (acc_e) q.push_back(d);
      fresh = 1'b0;
      #1;
      sENQ = 1'b0;
      dDEQ = 1'b0;
   endtask

   task automatic test_reset();
      sRST = 1'b1; sENQ = 1'b0; dDEQ = 1'b0; sD_IN = '0;
      q.delete(); fresh = 1'b1;
      repeat (5) begin
         @(posedge sCLK); #1;
         n_vec++;
         if (sFULL_N !== 1'b0) begin n_err++; $display("FAIL reset_full_n: got %b required 0", sFULL_N); end
         n_vec++;
         if (dEMPTY_N !== 1'b0) begin n_err++; $display("FAIL reset_empty_n: got %b required 0", dEMPTY_N); end
      end
      sRST = 1'b0;
      #1;
      n_vec++;
      if (sFULL_N !== 1'b0) begin n_err++; $display("FAIL release_before_edge_full_n: got %b required 0", sFULL_N); end
      @(posedge sCLK); #1;
      fresh = 1'b0;
      n_vec++;
      if (sFULL_N !== 1'b1) begin n_err++; $display("FAIL release_full_n: got %b required 1", sFULL_N); end
      n_vec++;
      if (dEMPTY_N !== 1'b0) begin n_err++; $display("FAIL release_empty_n: got %b required 0", dEMPTY_N); end
   endtask

   task automatic test_single();
      cycle(1'b1, 11'h5A3, 1'b0);
      n_vec++;
      if (dEMPTY_N !== 1'b1) begin n_err++; $display("FAIL single_empty_n: got %b required 1", dEMPTY_N); end
      n_vec++;
      if (dD_OUT !== 11'h5A3) begin n_err++; $display("FAIL single_dout: got %h required 5a3", dD_OUT); end
      cycle(1'b0, '0, 1'b1);
      n_vec++;
      if (dEMPTY_N !== 1'b0) begin n_err++; $display("FAIL single_drain_empty_n: got %b required 0", dEMPTY_N); end
   endtask

   task automatic test_fill_overflow();
      logic [DW-1:0] exp;
      for (int i = 1; i <= DEPTH; i++) cycle(1'b1, DW'(i), 1'b0);
      n_vec++;
      if (sFULL_N !== 1'b0) begin n_err++; $display("FAIL fill_full_n: got %b required 0", sFULL_N); end
      cycle(1'b1, 11'h7FF, 1'b0);
      n_vec++;
      if (sFULL_N !== 1'b0) begin n_err++; $display("FAIL overflow_full_n: got %b required 0", sFULL_N); end
      for (int i = 1; i <= DEPTH; i++) begin
         exp = DW'(i);
         n_vec++;
         if (dD_OUT !== exp) begin n_err++; $display("FAIL drain_word%0d: got %h required %h", i, dD_OUT, exp); end
         cycle(1'b0, '0, 1'b1);
      end
      n_vec++;
      if (dEMPTY_N !== 1'b0) begin n_err++; $display("FAIL drain_empty_n: got %b required 0", dEMPTY_N); end
      n_vec++;
      if (sFULL_N !== 1'b1) begin n_err++; $display("FAIL drain_full_n: got %b required 1", sFULL_N); end
   endtask

   task automatic test_underflow();
      repeat (3) begin
         cycle(1'b0, '0, 1'b1);
         n_vec++;
         if (dEMPTY_N !== 1'b0 || sFULL_N !== 1'b1) begin
            n_err++; $display("FAIL underflow_flags: got empty_n=%b full_n=%b required 0/1", dEMPTY_N, sFULL_N);
         end
      end
      cycle(1'b1, 11'h123, 1'b0);
      n_vec++;
      if (dD_OUT !== 11'h123 || dEMPTY_N !== 1'b1) begin
         n_err++; $display("FAIL underflow_readback: got %h/%b required 123/1", dD_OUT, dEMPTY_N);
      end
      cycle(1'b0, '0, 1'b1);
      n_vec++;
      if (dEMPTY_N !== 1'b0) begin n_err++; $display("FAIL underflow_final_empty_n: got %b required 0", dEMPTY_N); end
   endtask

   task automatic test_streaming();
      logic [DW-1:0] sent[$];
      logic [DW-1:0] w;
      int n_sent = 0;
      int n_rcv  = 0;
      int k      = 0;
      while ((n_sent < 64 || n_rcv < n_sent) && k < 1000) begin
         if ((k % 2) == 0) begin
            if (sFULL_N && n_sent < 64) begin
               w = DW'($urandom());
               sent.push_back(w);
               n_sent++;
               cycle(1'b1, w, 1'b0);
            end else cycle(1'b0, '0, 1'b0);
         end else begin
            if (dEMPTY_N) begin
               n_vec++;
               if (dD_OUT !== sent[n_rcv]) begin
                  n_err++; $display("FAIL stream_word%0d: got %h required %h", n_rcv, dD_OUT, sent[n_rcv]);
               end
               n_rcv++;
               cycle(1'b0, '0, 1'b1);
            end else cycle(1'b0, '0, 1'b0);
         end
         n_vec++;
         if (dEMPTY_N !== (q.size() != 0) || sFULL_N !== (q.size() != DEPTH)) begin
            n_err++; $display("FAIL stream_flags: got empty_n=%b full_n=%b required %b/%b",
                              dEMPTY_N, sFULL_N, q.size() != 0, q.size() != DEPTH);
         end
         k++;
      end
      n_vec++;
      if (n_rcv != 64) begin n_err++; $display("FAIL stream_count: got %0d required 64", n_rcv); end
   endtask

   task automatic test_full_simul();
      logic [DW-1:0] w;
      for (int i = 0; i < DEPTH; i++) begin
         w = DW'($urandom());
         cycle(1'b1, w, 1'b0);
      end
      n_vec++;
      if (sFULL_N !== 1'b0) begin n_err++; $display("FAIL simul_fill_full_n: got %b required 0", sFULL_N); end
      cycle(1'b1, 11'h0AA, 1'b1);
      n_vec++;
      if (sFULL_N !== 1'b1) begin n_err++; $display("FAIL simul_full_n: got %b required 1", sFULL_N); end
      n_vec++;
      if (q.size() != DEPTH - 1) begin n_err++; $display("FAIL simul_model_count: got %0d required 3", q.size()); end
      for (int i = 0; i < DEPTH - 1; i++) begin
         n_vec++;
         if (dEMPTY_N !== 1'b1 || dD_OUT !== q[0]) begin
            n_err++; $display("FAIL simul_drain%0d: got %h/%b required %h/1", i, dD_OUT, dEMPTY_N, q[0]);
         end
         cycle(1'b0, '0, 1'b1);
      end
      n_vec++;
      if (dEMPTY_N !== 1'b0) begin n_err++; $display("FAIL simul_final_empty_n: got %b required 0", dEMPTY_N); end
   endtask

   task automatic test_midreset();
      cycle(1'b1, 11'h201, 1'b0);
      cycle(1'b1, 11'h202, 1'b0);
      cycle(1'b1, 11'h203, 1'b0);
      #2;
      sRST = 1'b1;
      #1;
      n_vec++;
      if (sFULL_N !== 1'b0 || dEMPTY_N !== 1'b0) begin
         n_err++; $display("FAIL midreset_async: got full_n=%b empty_n=%b required 0/0", sFULL_N, dEMPTY_N);
      end
      sENQ = 1'b1; dDEQ = 1'b1; sD_IN = 11'h3FF;
      repeat (2) begin
         @(posedge sCLK); #1;
         n_vec++;
         if (sFULL_N !== 1'b0 || dEMPTY_N !== 1'b0) begin
            n_err++; $display("FAIL midreset_hold: got full_n=%b empty_n=%b required 0/0", sFULL_N, dEMPTY_N);
         end
      end
      sENQ = 1'b0; dDEQ = 1'b0;
      sRST = 1'b0;
      q.delete(); fresh = 1'b1;
      // An enqueue on the first edge after release meets sFULL_N=0 and is dropped.
      cycle(1'b1, 11'h111, 1'b0);
      n_vec++;
      if (sFULL_N !== 1'b1 || dEMPTY_N !== 1'b0) begin
         n_err++; $display("FAIL midreset_release: got full_n=%b empty_n=%b required 1/0", sFULL_N, dEMPTY_N);
      end
      cycle(1'b1, 11'h3C3, 1'b0);
      n_vec++;
      if (dD_OUT !== 11'h3C3 || dEMPTY_N !== 1'b1) begin
         n_err++; $display("FAIL midreset_readback: got %h/%b required 3c3/1", dD_OUT, dEMPTY_N);
      end
      cycle(1'b0, '0, 1'b1);
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill_overflow();
      test_underflow();
      test_streaming();
      test_full_simul();
      test_midreset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
